// File: rtl/cpu_dbg_scanner_pkg.sv
// cpu_dbg_scanner_pkg: scanner FSM states and output stream tag codes.
package cpu_dbg_scanner_pkg;
   typedef enum logic [2:0] {S_IDLE, S_PC, S_INST, S_RF, S_MEM, S_FIN} state_t;
   localparam logic [1:0] TAG_PC   = 2'd0;
   localparam logic [1:0] TAG_INST = 2'd1;
   localparam logic [1:0] TAG_GPR  = 2'd2;
   localparam logic [1:0] TAG_MEM  = 2'd3;
endpackage

// File: rtl/cpu_dbg_scanner_if.sv
// cpu_dbg_scanner_if: tagged valid/ready word stream from scanner to display formatter.
interface cpu_dbg_scanner_if;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_tag;
   logic [7:0]  out_idx;
   logic [31:0] out_data;
   modport master (output out_valid, out_tag, out_idx, out_data, input out_ready);
   modport slave (input out_valid, out_tag, out_idx, out_data, output out_ready);
endinterface

// File: rtl/cpu_dbg_scanner.sv
// cpu_dbg_scanner: snapshots PC/INST, then streams all GPRs and a data-RAM window as tagged words.
module cpu_dbg_scanner
   import cpu_dbg_scanner_pkg::*;
#(
   parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
   parameter int          MEM_WORDS = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic [4:0]          rf_addr,
   input  logic [31:0]         rf_data,
   output logic [31:0]         mem_addr,
   input  logic [31:0]         mem_data,
   input  logic [31:0]         cpu_pc,
   input  logic [31:0]         cpu_inst,
   cpu_dbg_scanner_if.master   dbg,
   output logic                busy,
   output logic                done
);
   localparam logic [7:0] LAST = 8'(MEM_WORDS - 1);
   state_t      state;
   logic [7:0]  cnt;
   logic [31:0] inst_q;
   logic        ld;
   assign ld       = !dbg.out_valid || dbg.out_ready;
   assign rf_addr  = cnt[4:0];
   assign mem_addr = MEM_BASE + {22'd0, cnt, 2'b00};
   assign busy     = state != S_IDLE;
   // The PC snapshot is the output slot itself: it is loaded on the start edge.
   // State names the word currently held in the slot; each load advances it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         cnt           <= 8'd0;
         inst_q        <= 32'd0;
         dbg.out_valid <= 1'b0;
         dbg.out_tag   <= TAG_PC;
         dbg.out_idx   <= 8'd0;
         dbg.out_data  <= 32'd0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               inst_q        <= cpu_inst;
               dbg.out_valid <= 1'b1;
               dbg.out_tag   <= TAG_PC;
               dbg.out_idx   <= 8'd0;
               dbg.out_data  <= cpu_pc;
               cnt           <= 8'd0;
               state         <= S_PC;
            end
            S_PC: if (ld) begin
               dbg.out_tag  <= TAG_INST;
               dbg.out_data <= inst_q;
               state        <= S_INST;
            end
            S_INST, S_RF: if (ld) begin
               dbg.out_tag  <= TAG_GPR;
               dbg.out_idx  <= cnt;
               dbg.out_data <= rf_data;
               cnt          <= (cnt == 8'd31) ? 8'd0 : cnt + 8'd1;
               state        <= (cnt == 8'd31) ? S_MEM : S_RF;
            end
            S_MEM: if (ld) begin
               dbg.out_tag  <= TAG_MEM;
               dbg.out_idx  <= cnt;
               dbg.out_data <= mem_data;
               cnt          <= (cnt == LAST) ? 8'd0 : cnt + 8'd1;
               state        <= (cnt == LAST) ? S_FIN : S_MEM;
            end
            S_FIN: if (dbg.out_ready) begin
               dbg.out_valid <= 1'b0;
               done          <= 1'b1;
               state         <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
